// File: rtl/imem_loader.sv
// imem_loader: assembles a length-prefixed big-endian byte stream into 32-bit words for instruction memory.
// Latency: a word is written one cycle after its fourth byte is accepted; done/error is flagged one cycle after that.
// Backpressure: rx_ready is high only while a frame is being received; an rx_valid stall simply pauses the load.
// Optional macro IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte (CHK state).
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_rx_ready,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  output logic                  o_busy,
  output logic                  o_load_done,
  output logic                  o_load_error,
  output logic [ADDR_WIDTH:0]   o_word_count,
  output logic                  o_cpu_hold
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  state_t                r_state;
  logic [7:0]            r_len_hi;
  logic [15:0]           r_len;
  logic [1:0]            r_byte_idx;
  logic [23:0]           r_shift;
  logic                  r_fin;
  logic                  r_rx_ready;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;
  logic                  r_busy;
  logic                  r_load_done;
  logic                  r_load_error;
  logic [ADDR_WIDTH:0]   r_word_count;
  logic                  r_cpu_hold;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            r_chk;
`endif

  logic        w_xfer;
  logic [15:0] w_len;
  logic        w_len_over;
  logic [15:0] w_next_count;

  // Handshake, candidate length from the low length byte, and the post-write word count.
  assign w_xfer       = i_rx_valid && r_rx_ready;
  assign w_len        = {r_len_hi, i_rx_data};
  assign w_len_over   = 32'(w_len) > DEPTH;
  assign w_next_count = 16'(r_word_count) + 16'd1;

  // Loader FSM; every output is a register updated here.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_len_hi     <= '0;
      r_len        <= '0;
      r_byte_idx   <= '0;
      r_shift      <= '0;
      r_fin        <= 1'b0;
      r_rx_ready   <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_busy       <= 1'b0;
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
      r_word_count <= '0;
      r_cpu_hold   <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_chk        <= '0;
`endif
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (i_start) begin
            r_state      <= S_LEN_HI;
            r_rx_ready   <= 1'b1;
            r_busy       <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
            r_word_count <= '0;
            r_cpu_hold   <= 1'b1;
            r_byte_idx   <= '0;
            r_fin        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_chk        <= '0;
`endif
          end
        end
        S_LEN_HI: begin
          if (w_xfer) begin
            r_len_hi <= i_rx_data;
            r_state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (w_xfer) begin
            r_len <= w_len;
            if (w_len == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              r_state <= S_CHK;
`else
              r_state     <= S_DONE;
              r_rx_ready  <= 1'b0;
              r_busy      <= 1'b0;
              r_load_done <= 1'b1;
              r_cpu_hold  <= 1'b0;
`endif
            end else if (w_len_over) begin
              // Oversized program: reject before any write so memory is untouched.
              r_state      <= S_ERROR;
              r_rx_ready   <= 1'b0;
              r_busy       <= 1'b0;
              r_load_error <= 1'b1;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (r_fin) begin
            // Last word was written on the previous cycle; release the core now.
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_load_done <= 1'b1;
            r_cpu_hold  <= 1'b0;
            r_fin       <= 1'b0;
          end else if (w_xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_chk <= r_chk ^ i_rx_data;
`endif
            if (r_byte_idx == 2'd3) begin
              r_mem_we     <= 1'b1;
              r_mem_addr   <= r_word_count[ADDR_WIDTH-1:0];
              r_mem_wdata  <= {r_shift, i_rx_data};
              r_word_count <= r_word_count + 1'b1;
              r_byte_idx   <= '0;
              if (w_next_count == r_len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_state <= S_CHK;
`else
                r_rx_ready <= 1'b0;
                r_fin      <= 1'b1;
`endif
              end
            end else begin
              r_shift    <= {r_shift[15:0], i_rx_data};
              r_byte_idx <= r_byte_idx + 2'd1;
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (w_xfer) begin
            r_rx_ready <= 1'b0;
            r_busy     <= 1'b0;
            if (i_rx_data == r_chk) begin
              r_state     <= S_DONE;
              r_load_done <= 1'b1;
              r_cpu_hold  <= 1'b0;
            end else begin
              // Written words stay in memory, but the core is kept in reset.
              r_state      <= S_ERROR;
              r_load_error <= 1'b1;
            end
          end
        end
`endif
        default: begin
          r_state    <= S_IDLE;
          r_rx_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign o_rx_ready   = r_rx_ready;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_busy       = r_busy;
  assign o_load_done  = r_load_done;
  assign o_load_error = r_load_error;
  assign o_word_count = r_word_count;
  assign o_cpu_hold   = r_cpu_hold;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (ADDR_WIDTH=8).
// Covers reset, back-to-back and stalled frames, N=0, oversize N, mid-load reset and the checksum build.
module tb_imem_loader;

  localparam int AW = 8;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_start = 1'b0;
  logic [7:0]    i_rx_data = '0;
  logic          i_rx_valid = 1'b0;
  logic          o_rx_ready;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [31:0]   o_mem_wdata;
  logic          o_busy;
  logic          o_load_done;
  logic          o_load_error;
  logic [AW:0]   o_word_count;
  logic          o_cpu_hold;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_busy(o_busy), .o_load_done(o_load_done), .o_load_error(o_load_error),
    .o_word_count(o_word_count), .o_cpu_hold(o_cpu_hold)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_cyc = 0;
  logic [7:0]    byte_q[$];
  logic [AW-1:0] wr_addr[$];
  logic [31:0]   wr_data[$];
  int            wr_cyc[$];

  always @(posedge i_clk) cyc++;

  // Log every memory write seen between edges.
  always @(negedge i_clk) begin
    if (o_mem_we) begin
      wr_addr.push_back(o_mem_addr);
      wr_data.push_back(o_mem_wdata);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic clear_log();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
  endtask

  task automatic do_start();
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  // Streams byte_q; gap=1 drops rx_valid for a cycle after each byte.
  task automatic send_frame(input bit gap, output bit ok);
    int n;
    ok = 1'b1;
    foreach (byte_q[i]) begin
      i_rx_data = byte_q[i];
      i_rx_valid = 1'b1;
      n = 0;
      while (!o_rx_ready && n < 50) begin
        @(posedge i_clk); #1; n++;
      end
      if (!o_rx_ready) begin
        ok = 1'b0;
        break;
      end
      @(posedge i_clk); #1;
      last_cyc = cyc;
      if (gap) begin
        i_rx_valid = 1'b0;
        @(posedge i_clk); #1;
      end
    end
    i_rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    total++; if (o_rx_ready !== 1'b0) begin bad++; $display("FAIL reset_rx_ready got=%b exp=0", o_rx_ready); end
    total++; if (o_mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%b exp=0", o_mem_we); end
    total++; if ({o_mem_addr, o_mem_wdata} !== '0) begin bad++; $display("FAIL reset_addr_data got=%h/%h exp=0", o_mem_addr, o_mem_wdata); end
    total++; if ({o_busy, o_load_done, o_load_error} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {o_busy, o_load_done, o_load_error}); end
    total++; if (o_word_count !== '0) begin bad++; $display("FAIL reset_word_count got=%0d exp=0", o_word_count); end
    total++; if (o_cpu_hold !== 1'b1) begin bad++; $display("FAIL reset_cpu_hold got=%b exp=1", o_cpu_hold); end
    i_rst = 1'b0;
    @(posedge i_clk); #1;
  endtask

  // Two-word frame; gap selects stalled or back-to-back streaming.
  task automatic run_two_word(input bit gap, input string tag);
    bit ok;
    clear_log();
    do_start();
    total++; if ({o_rx_ready, o_busy, o_cpu_hold} !== 3'b111) begin bad++; $display("FAIL %s_start got=%b exp=111", tag, {o_rx_ready, o_busy, o_cpu_hold}); end
    byte_q = '{8'h00, 8'h02, 8'h7C, 8'h22, 8'h1A, 8'h14, 8'h38, 8'h20, 8'h00, 8'h05};
`ifdef IMEM_LOADER_CHECKSUM_EN
    byte_q.push_back(8'h4D);
`endif
    send_frame(gap, ok);
    total++; if (!ok) begin bad++; $display("FAIL %s_timeout got=stuck exp=accepted", tag); end
`ifndef IMEM_LOADER_CHECKSUM_EN
    if (!gap) begin
      total++; if ({o_mem_we, o_rx_ready, o_load_done} !== 3'b100) begin bad++; $display("FAIL %s_t1 got=%b exp=100", tag, {o_mem_we, o_rx_ready, o_load_done}); end
    end
    @(posedge i_clk); #1;
`endif
    total++; if ({o_load_done, o_cpu_hold, o_busy, o_load_error} !== 4'b1000) begin bad++; $display("FAIL %s_done got=%b exp=1000", tag, {o_load_done, o_cpu_hold, o_busy, o_load_error}); end
    total++; if (o_word_count !== 9'd2) begin bad++; $display("FAIL %s_count got=%0d exp=2", tag, o_word_count); end
    total++; if (wr_addr.size() !== 2) begin bad++; $display("FAIL %s_nwrites got=%0d exp=2", tag, wr_addr.size()); end
    if (wr_addr.size() == 2) begin
      total++; if ({wr_addr[0], wr_data[0]} !== {8'd0, 32'h7C221A14}) begin bad++; $display("FAIL %s_w0 got=%h:%h exp=00:7c221a14", tag, wr_addr[0], wr_data[0]); end
      total++; if ({wr_addr[1], wr_data[1]} !== {8'd1, 32'h38200005}) begin bad++; $display("FAIL %s_w1 got=%h:%h exp=01:38200005", tag, wr_addr[1], wr_data[1]); end
      if (!gap) begin
        total++; if (wr_cyc[1] - wr_cyc[0] !== 4) begin bad++; $display("FAIL %s_spacing got=%0d exp=4", tag, wr_cyc[1] - wr_cyc[0]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    run_two_word(1'b0, "b2b");
  endtask

  task automatic test_stall();
    run_two_word(1'b1, "stall");
  endtask

  task automatic test_zero_len();
    bit ok;
    clear_log();
    do_start();
    byte_q = '{8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    byte_q.push_back(8'h00);
`endif
    send_frame(1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL zero_timeout got=stuck exp=accepted"); end
    total++; if ({o_load_done, o_cpu_hold, o_rx_ready, o_word_count} !== {3'b100, 9'd0}) begin bad++; $display("FAIL zero_done got=%b/%0d exp=100/0", {o_load_done, o_cpu_hold, o_rx_ready}, o_word_count); end
    repeat (2) @(posedge i_clk);
    #1;
    total++; if (wr_addr.size() !== 0) begin bad++; $display("FAIL zero_writes got=%0d exp=0", wr_addr.size()); end
  endtask

  task automatic test_oversize();
    bit ok;
    clear_log();
    do_start();
    byte_q = '{8'h01, 8'h01};
    send_frame(1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL over_timeout got=stuck exp=accepted"); end
    total++; if ({o_load_error, o_cpu_hold, o_rx_ready, o_busy, o_load_done} !== 5'b11000) begin bad++; $display("FAIL over_error got=%b exp=11000", {o_load_error, o_cpu_hold, o_rx_ready, o_busy, o_load_done}); end
    repeat (3) @(posedge i_clk);
    #1;
    total++; if (wr_addr.size() !== 0 || o_rx_ready !== 1'b0) begin bad++; $display("FAIL over_quiet got=%0d writes rdy=%b exp=0 writes rdy=0", wr_addr.size(), o_rx_ready); end
  endtask

  task automatic test_reset_abort();
    bit ok;
    clear_log();
    do_start();
    byte_q = '{8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    send_frame(1'b0, ok);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    total++; if ({o_rx_ready, o_mem_we, o_busy, o_load_done, o_load_error, o_cpu_hold} !== 6'b000001 || o_word_count !== '0 || o_mem_addr !== '0 || o_mem_wdata !== '0) begin
      bad++; $display("FAIL abort_reset got=%b cnt=%0d addr=%h data=%h exp=000001 0 0 0", {o_rx_ready, o_mem_we, o_busy, o_load_done, o_load_error, o_cpu_hold}, o_word_count, o_mem_addr, o_mem_wdata);
    end
    i_rst = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    total++; if (wr_addr.size() !== 1) begin bad++; $display("FAIL abort_writes got=%0d exp=1", wr_addr.size()); end
    else begin
      total++; if ({wr_addr[0], wr_data[0]} !== {8'd0, 32'hAABBCCDD}) begin bad++; $display("FAIL abort_w0 got=%h:%h exp=00:aabbccdd", wr_addr[0], wr_data[0]); end
    end
    clear_log();
    do_start();
    byte_q = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef IMEM_LOADER_CHECKSUM_EN
    byte_q.push_back(8'h22);
`endif
    send_frame(1'b0, ok);
    repeat (2) @(posedge i_clk);
    #1;
    total++; if (!ok || o_load_done !== 1'b1 || o_cpu_hold !== 1'b0) begin bad++; $display("FAIL abort_reload got=ok%b done%b hold%b exp=ok1 done1 hold0", ok, o_load_done, o_cpu_hold); end
    total++; if (wr_data.size() !== 1 || wr_data[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL abort_reload_w got=%0d writes exp=1 write deadbeef", wr_data.size()); end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    bit ok;
    clear_log();
    do_start();
    byte_q = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    send_frame(1'b0, ok);
    total++; if (!ok || {o_load_done, o_load_error, o_cpu_hold} !== 3'b100) begin bad++; $display("FAIL chk_good got=%b exp=100", {o_load_done, o_load_error, o_cpu_hold}); end
    clear_log();
    do_start();
    byte_q = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    send_frame(1'b0, ok);
    total++; if (!ok || {o_load_done, o_load_error, o_cpu_hold, o_rx_ready} !== 4'b0110) begin bad++; $display("FAIL chk_bad got=%b exp=0110", {o_load_done, o_load_error, o_cpu_hold, o_rx_ready}); end
    total++; if (wr_data.size() !== 1 || wr_data[0] !== 32'h11223344) begin bad++; $display("FAIL chk_bad_write got=%0d writes exp=1 write 11223344", wr_data.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_zero_len();
    test_oversize();
    test_reset_abort();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
